// File: rtl/gps_accum_dump_master.sv
// AXI4-Lite read master: on each accum_int rising edge, reads NUM_WORDS registers from BASE_ADDR
// and streams them out. Define GPS_DUMP_OVERRUN_CNT_EN to add the overrun_cnt/overrun_clr ports.
module gps_accum_dump_master #(
    parameter int                        AXI_ADDR_WIDTH = 32,
    parameter int                        AXI_DATA_WIDTH = 32,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 'h40,
    parameter int                        NUM_WORDS      = 8,
    parameter int                        IDX_W          = 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      enable,
    input  logic                      accum_int,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0] m_tdata,
    output logic [IDX_W-1:0]          m_tidx,
    output logic                      m_tlast,
    output logic                      m_terr,
    output logic                      m_tvalid,
    input  logic                      m_tready,
`ifdef GPS_DUMP_OVERRUN_CNT_EN
    input  logic                      overrun_clr,
    output logic [15:0]               overrun_cnt,
`endif
    output logic                      busy
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_OUT} state_t;

    state_t                    r_state, w_state_nxt;
    logic                      r_accum_q, r_trig, r_pending;
    logic [IDX_W-1:0]          r_idx;
    logic [AXI_ADDR_WIDTH-1:0] r_araddr;
    logic [AXI_DATA_WIDTH-1:0] r_tdata;
    logic [IDX_W-1:0]          r_tidx;
    logic                      r_tlast, r_terr;
    logic                      w_last, w_start, w_r_hs, w_t_hs;

    assign w_last  = (r_idx == IDX_W'(NUM_WORDS - 1));
    assign w_start = (r_state == S_IDLE) && (r_trig || r_pending);
    assign w_r_hs  = (r_state == S_R) && m_axi_rvalid;
    assign w_t_hs  = (r_state == S_OUT) && m_tready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        m_tvalid      = 1'b0;
        case (r_state)
            S_IDLE: if (r_trig || r_pending) w_state_nxt = S_AR;
            S_AR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) w_state_nxt = S_R;
            end
            S_R: begin
                m_axi_rready = 1'b1;
                if (m_axi_rvalid) w_state_nxt = S_OUT;
            end
            S_OUT: begin
                m_tvalid = 1'b1;
                if (m_tready) w_state_nxt = r_tlast ? S_IDLE : S_AR;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Edge detect is registered so the trigger reaches IDLE one cycle later.
    // In IDLE a pending request is consumed; a simultaneous new edge takes its place.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_accum_q <= 1'b0;
            r_trig    <= 1'b0;
            r_pending <= 1'b0;
            r_idx     <= '0;
            r_araddr  <= '0;
            r_tdata   <= '0;
            r_tidx    <= '0;
            r_tlast   <= 1'b0;
            r_terr    <= 1'b0;
        end else begin
            r_accum_q <= accum_int;
            r_trig    <= accum_int & ~r_accum_q & enable;
            r_pending <= (r_state == S_IDLE) ? (r_pending & r_trig) : (r_pending | r_trig);
            if (w_start) begin
                r_idx    <= '0;
                r_araddr <= BASE_ADDR;
            end else if (w_t_hs && !r_tlast) begin
                r_idx    <= r_idx + IDX_W'(1);
                r_araddr <= r_araddr + AXI_ADDR_WIDTH'(4);
            end
            if (w_r_hs) begin
                r_tdata <= m_axi_rdata;
                r_terr  <= |m_axi_rresp;
                r_tidx  <= r_idx;
                r_tlast <= w_last;
            end
        end
    end

    assign m_axi_araddr = r_araddr;
    assign m_tdata      = r_tdata;
    assign m_tidx       = r_tidx;
    assign m_tlast      = r_tlast;
    assign m_terr       = r_terr;
    assign busy         = (r_state != S_IDLE) | r_pending;

`ifdef GPS_DUMP_OVERRUN_CNT_EN
    logic        w_overrun;
    logic [15:0] r_overrun_cnt;

    assign w_overrun = r_trig && r_pending && (r_state != S_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)                                    r_overrun_cnt <= '0;
        else if (overrun_clr)                            r_overrun_cnt <= '0;
        else if (w_overrun && r_overrun_cnt != 16'hFFFF) r_overrun_cnt <= r_overrun_cnt + 16'd1;
    end

    assign overrun_cnt = r_overrun_cnt;
`endif

endmodule

// File: tb/tb_gps_accum_dump_master.sv
// Directed bench for gps_accum_dump_master: AXI-Lite slave model returning rdata=addr,
// stream sink with programmable stall, scoreboard of expected addresses and stream words.
module tb_gps_accum_dump_master;

    localparam int NW = 8;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  idx;
        logic        last;
        logic        err;
    } exp_t;

    logic        aclk = 1'b0, aresetn = 1'b0, enable = 1'b0, accum_int = 1'b0;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid, m_axi_rready;
    logic        m_axi_arready = 1'b0, m_axi_rvalid = 1'b0;
    logic [31:0] m_axi_rdata = '0;
    logic [1:0]  m_axi_rresp = '0;
    logic [31:0] m_tdata;
    logic [7:0]  m_tidx;
    logic        m_tlast, m_terr, m_tvalid, busy;
    logic        m_tready = 1'b1;
`ifdef GPS_DUMP_OVERRUN_CNT_EN
    logic        overrun_clr = 1'b0;
    logic [15:0] overrun_cnt;
`endif

    int          n_tests = 0, n_fail = 0;
    exp_t        sb_q[$];
    logic [31:0] addr_q[$];
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          ar_delay = 0, s_wait = 0, stall_len = 0, stall_cnt = 0;
    logic [31:0] s_addr = '0;
    logic        p_tvalid = 1'b0, p_tready = 1'b0, p_arvalid = 1'b0, p_arready = 1'b0;
    logic [31:0] p_tdata = '0, p_araddr = '0;
    logic [7:0]  p_tidx = '0;

    gps_accum_dump_master #(.NUM_WORDS(NW)) dut (
        .aclk(aclk), .aresetn(aresetn), .enable(enable), .accum_int(accum_int),
        .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready),
        .m_tdata(m_tdata), .m_tidx(m_tidx), .m_tlast(m_tlast), .m_terr(m_terr),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
`ifdef GPS_DUMP_OVERRUN_CNT_EN
        .overrun_clr(overrun_clr), .overrun_cnt(overrun_cnt),
`endif
        .busy(busy)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_dump();
        for (int i = 0; i < NW; i++) begin
            exp_t e;
            e.data = 32'h40 + 32'(4 * i);
            e.idx  = 8'(i);
            e.last = (i == NW - 1);
            e.err  = (e.data == err_addr);
            addr_q.push_back(e.data);
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse();
        @(negedge aclk) accum_int = 1'b1;
        @(negedge aclk) accum_int = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while ((busy || sb_q.size() != 0) && k < 3000) begin
            @(negedge aclk);
            k++;
        end
        check({tag, "_words_left"}, 32'(sb_q.size()), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        repeat (3) @(negedge aclk);
    endtask

    // Protocol monitor, AXI slave model and stream sink share one process so their
    // per-cycle ordering is fixed: check last cycle's holds, drive, then snapshot.
    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_arready = 1'b0;
            m_axi_rvalid  = 1'b0;
            m_tready      = 1'b1;
            s_wait        = 0;
            p_tvalid      = 1'b0;
            p_arvalid     = 1'b0;
        end else begin
            if (p_arvalid && !p_arready) begin
                check("arvalid_hold", 32'(m_axi_arvalid), 1);
                check("araddr_hold", m_axi_araddr, p_araddr);
            end
            if (p_tvalid && !p_tready) begin
                check("tvalid_hold", 32'(m_tvalid), 1);
                check("tdata_hold", m_tdata, p_tdata);
                check("tidx_hold", 32'(m_tidx), 32'(p_tidx));
            end
            if (m_tvalid) check("no_ar_during_out", 32'(m_axi_arvalid), 0);

            if (m_axi_rvalid) m_axi_rvalid = 1'b0;
            else if (m_axi_arready) begin
                m_axi_arready = 1'b0;
                m_axi_rvalid  = 1'b1;
                m_axi_rdata   = s_addr;
                m_axi_rresp   = (s_addr == err_addr) ? 2'b10 : 2'b00;
            end else if (m_axi_arvalid) begin
                if (s_wait >= ar_delay) begin
                    m_axi_arready = 1'b1;
                    s_addr        = m_axi_araddr;
                    s_wait        = 0;
                    if (addr_q.size() == 0) check("araddr_unexpected", m_axi_araddr, 32'hDEAD_BEEF);
                    else check("araddr", m_axi_araddr, addr_q.pop_front());
                end else s_wait++;
            end

            if (m_tvalid && m_tidx == 8'd1 && stall_cnt < stall_len) begin
                m_tready = 1'b0;
                stall_cnt++;
            end else m_tready = 1'b1;

            if (m_tvalid && m_tready) begin
                if (sb_q.size() == 0) check("word_unexpected", m_tdata, 32'hDEAD_BEEF);
                else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("tdata", m_tdata, e.data);
                    check("tidx", 32'(m_tidx), 32'(e.idx));
                    check("tlast", 32'(m_tlast), 32'(e.last));
                    check("terr", 32'(m_terr), 32'(e.err));
                end
            end

            p_tvalid  = m_tvalid;
            p_tready  = m_tready;
            p_tdata   = m_tdata;
            p_tidx    = m_tidx;
            p_arvalid = m_axi_arvalid;
            p_arready = m_axi_arready;
            p_araddr  = m_axi_araddr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Reset state
        #12;
        check("rst_arvalid", 32'(m_axi_arvalid), 0);
        check("rst_araddr", m_axi_araddr, 0);
        check("rst_rready", 32'(m_axi_rready), 0);
        check("rst_tvalid", 32'(m_tvalid), 0);
        check("rst_tdata", m_tdata, 0);
        check("rst_tidx", 32'(m_tidx), 0);
        check("rst_tlast", 32'(m_tlast), 0);
        check("rst_terr", 32'(m_terr), 0);
        check("rst_busy", 32'(busy), 0);
`ifdef GPS_DUMP_OVERRUN_CNT_EN
        check("rst_overrun", 32'(overrun_cnt), 0);
`endif
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge aclk);

        // Single dump with trigger-to-arvalid latency
        push_dump();
        pulse();
        check("lat_cycle1_arvalid", 32'(m_axi_arvalid), 0);
        @(negedge aclk);
        check("lat_cycle2_arvalid", 32'(m_axi_arvalid), 1);
        check("lat_cycle2_araddr", m_axi_araddr, 32'h40);
        check("lat_cycle2_busy", 32'(busy), 1);
        wait_done("dump_basic");

        // Stream stalled 10 cycles on word 1
        stall_cnt = 0;
        stall_len = 10;
        push_dump();
        pulse();
        wait_done("dump_stall");
        check("stall_cycles", 32'(stall_cnt), 10);
        stall_len = 0;

        // arready delayed 5 cycles on every word
        ar_delay = 5;
        push_dump();
        pulse();
        wait_done("dump_ar_delay");
        ar_delay = 0;

        // SLVERR on word 2 only
        err_addr = 32'h48;
        push_dump();
        pulse();
        wait_done("dump_err");
        err_addr = 32'hFFFF_FFFF;

        // Trigger ignored while disabled
        enable = 1'b0;
        pulse();
        repeat (4) @(negedge aclk);
        check("disabled_busy", 32'(busy), 0);
        check("disabled_arvalid", 32'(m_axi_arvalid), 0);
        enable = 1'b1;

        // Three pulses: one dump, one follow-up, one dropped
        push_dump();
        push_dump();
        pulse();
        repeat (4) @(negedge aclk);
        pulse();
        repeat (4) @(negedge aclk);
        pulse();
        @(negedge aclk);
        check("overrun_busy", 32'(busy), 1);
`ifdef GPS_DUMP_OVERRUN_CNT_EN
        check("overrun_cnt_1", 32'(overrun_cnt), 1);
`endif
        wait_done("dump_overrun");
        repeat (5) @(negedge aclk);
        check("overrun_no_third_dump", 32'(busy), 0);
`ifdef GPS_DUMP_OVERRUN_CNT_EN
        check("overrun_cnt_held", 32'(overrun_cnt), 1);
        overrun_clr = 1'b1;
        @(negedge aclk) overrun_clr = 1'b0;
        check("overrun_cnt_clr", 32'(overrun_cnt), 0);
`endif

        // Pending request survives enable dropping mid-dump
        push_dump();
        push_dump();
        pulse();
        repeat (3) @(negedge aclk);
        pulse();
        enable = 1'b0;
        wait_done("dump_pending_disabled");
        enable = 1'b1;

        // Asynchronous reset while waiting for read data
        push_dump();
        pulse();
        k = 0;
        while (!m_axi_rready && k < 50) begin
            @(negedge aclk);
            k++;
        end
        check("reach_r_state", 32'(m_axi_rready), 1);
        #2 aresetn = 1'b0;
        #1;
        check("arst_arvalid", 32'(m_axi_arvalid), 0);
        check("arst_rready", 32'(m_axi_rready), 0);
        check("arst_tvalid", 32'(m_tvalid), 0);
        check("arst_busy", 32'(busy), 0);
        sb_q.delete();
        addr_q.delete();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        push_dump();
        pulse();
        @(negedge aclk);
        check("post_rst_araddr", m_axi_araddr, 32'h40);
        wait_done("dump_post_reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
